hazard_scoreboard: RTL and testbench

//  Parametrised successor to the pipeline's separate hazard-detection and forwarding units.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/sb_match.sv | 31 +++
 rtl/hazard_scoreboard.sv | 79 +++++++
 tb/tb_hazard_scoreboard.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the hazard scoreboard: in-flight write entry and
// forwarding-select codes.
package pipe_pkg;
    localparam int AW = 5;

    localparam int FWD_RF    = 0;
    localparam int FWD_EXMEM = 1;
    localparam int FWD_MEMWB = 2;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
        logic          regwrite;
        logic          is_load;
    } sb_entry_t;
endpackage

// File: rtl/sb_match.sv
// Compares one source operand against the tracked in-flight writes and returns
// the load-use hazard bit and the youngest-producer forwarding code.
module sb_match
    import pipe_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_RDY = 2,
    parameter int SW       = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-2:0] ent,
    input  logic [AW-1:0]         rs,
    input  logic                  use_en,
    output logic                  hazard,
    output logic [SW-1:0]         code
);

    // Walk oldest to youngest so the youngest match is the one left in code.
    always_comb begin
        hazard = 1'b0;
        code   = SW'(FWD_RF);
        for (int s = DEPTH - 2; s >= 0; s--) begin
            if (use_en && ent[s].valid && ent[s].regwrite &&
                ent[s].rd != '0 && ent[s].rd == rs) begin
                code = SW'(s + 1);
                if (ent[s].is_load && (s + 1 < LOAD_RDY))
                    hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes behind ID and produces load-use stall,
// ID/EX bubble and registered per-operand forwarding selects for EX.
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int  AW       = pipe_pkg::AW,
    parameter int  NUM_SRC  = 2,
    parameter int  DEPTH    = 3,
    parameter int  LOAD_RDY = 2,
    parameter int  CNT_W    = 32,
    localparam int SW       = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    id_valid_i,
    input  logic [NUM_SRC*AW-1:0]   id_rs_i,
    input  logic [NUM_SRC-1:0]      id_use_i,
    input  logic [AW-1:0]           id_rd_i,
    input  logic                    id_regwrite_i,
    input  logic                    id_is_load_i,
    input  logic                    flush_i,
    output logic                    stall_o,
    output logic                    bubble_o,
    output logic [NUM_SRC*SW-1:0]   fwd_sel_o,
    output logic                    ex_valid_o,
    output logic [CNT_W-1:0]        stall_cnt_o
);

    // The last stage (WB) is never consulted: the register file writes through,
    // so only stages 0..DEPTH-2 are stored.
    sb_entry_t [DEPTH-2:0]   pipe;
    logic [NUM_SRC-1:0]      haz;
    logic [NUM_SRC*SW-1:0]   code;
    logic                    issue;

    genvar k;
    generate
        for (k = 0; k < NUM_SRC; k++) begin : g_src
            sb_match #(
                .DEPTH    (DEPTH),
                .LOAD_RDY (LOAD_RDY),
                .SW       (SW)
            ) u_match (
                .ent    (pipe),
                .rs     (id_rs_i[k*AW +: AW]),
                .use_en (id_use_i[k]),
                .hazard (haz[k]),
                .code   (code[k*SW +: SW])
            );
        end
    endgenerate

    // Flush overrides stall: a killed instruction cannot be waiting on anything.
    assign stall_o  = id_valid_i & ~flush_i & (|haz);
    assign issue    = id_valid_i & ~flush_i & ~stall_o;
    assign bubble_o = ~issue;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pipe        <= '0;
            fwd_sel_o   <= '0;
            ex_valid_o  <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            if (issue)
                pipe[0] <= '{valid: 1'b1, rd: id_rd_i,
                             regwrite: id_regwrite_i, is_load: id_is_load_i};
            else
                pipe[0] <= '0;
            for (int s = 1; s < DEPTH - 1; s++)
                pipe[s] <= pipe[s-1];
            fwd_sel_o  <= issue ? code : '0;
            ex_valid_o <= issue;
            if (stall_o && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: default build plus a NUM_SRC=3/DEPTH=4/LOAD_RDY=3
// build, checked against a producer-list model keyed by issue cycle.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    typedef struct packed {
        logic vld, flush, rw, ld;
        logic [2:0] usem;
        logic [2:0][4:0] rs;
        logic [4:0] rd;
    } ins_t;
    typedef struct { int cyc; logic [4:0] rd; bit rw; bit ld; } rec_t;
    localparam ins_t IDLE = '0;

    logic a_vld, a_rw, a_ld, a_fl, a_stall, a_bub, a_exv;
    logic [9:0] a_rs; logic [1:0] a_use; logic [4:0] a_rd;
    logic [3:0] a_fwd; logic [31:0] a_cnt;
    logic b_vld, b_rw, b_ld, b_fl, b_stall, b_bub, b_exv;
    logic [14:0] b_rs; logic [2:0] b_use; logic [4:0] b_rd;
    logic [5:0] b_fwd; logic [31:0] b_cnt;

    hazard_scoreboard u_a (
        .clk_i(clk), .rst_i(rst_n), .id_valid_i(a_vld), .id_rs_i(a_rs), .id_use_i(a_use),
        .id_rd_i(a_rd), .id_regwrite_i(a_rw), .id_is_load_i(a_ld), .flush_i(a_fl),
        .stall_o(a_stall), .bubble_o(a_bub), .fwd_sel_o(a_fwd), .ex_valid_o(a_exv),
        .stall_cnt_o(a_cnt));

    hazard_scoreboard #(.NUM_SRC(3), .DEPTH(4), .LOAD_RDY(3)) u_b (
        .clk_i(clk), .rst_i(rst_n), .id_valid_i(b_vld), .id_rs_i(b_rs), .id_use_i(b_use),
        .id_rd_i(b_rd), .id_regwrite_i(b_rw), .id_is_load_i(b_ld), .flush_i(b_fl),
        .stall_o(b_stall), .bubble_o(b_bub), .fwd_sel_o(b_fwd), .ex_valid_o(b_exv),
        .stall_cnt_o(b_cnt));

    int passed = 0, total = 0, now = 0, cnta = 0, cntb = 0;
    rec_t qa[$], qb[$];
    bit os_a, ob_a, es_a, eb_a, oe_a, ee_a, os_b, ob_b, es_b, eb_b, oe_b, ee_b;
    logic [3:0] of_a, ef_a; logic [5:0] of_b, ef_b;
    logic [31:0] oc_a, ec_a, oc_b, ec_b;

    // Producer issued in cycle c sits in stage now-c-1; its result is usable
    // from stage rdy-1 onward, so a consumer must stall while stage+1 < rdy.
    function automatic void model(input rec_t q[$], input int depth, input int ldr,
                                  input int nsrc, input ins_t in,
                                  output bit st, output logic [5:0] fw);
        int best, stg;
        st = 0; fw = '0;
        for (int k = 0; k < nsrc; k++) begin
            best = depth;
            if (!in.usem[k]) continue;
            foreach (q[i]) begin
                stg = now - q[i].cyc - 1;
                if (stg < 0 || stg > depth - 2 || !q[i].rw || q[i].rd == 0 || q[i].rd != in.rs[k])
                    continue;
                if (stg + 1 < (q[i].ld ? ldr : 1)) st = 1;
                if (stg < best) best = stg;
            end
            if (best < depth) fw[k*2 +: 2] = 2'(best + 1);
        end
        st = st & in.vld & ~in.flush;
    endfunction

    function automatic ins_t mk(input logic [4:0] rd, input bit rw, input bit ld,
                                input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [2:0] u, input bit fl);
        ins_t x = '0;
        x.vld = 1'b1; x.flush = fl; x.rw = rw; x.ld = ld; x.usem = u;
        x.rs[0] = r0; x.rs[1] = r1; x.rs[2] = r2; x.rd = rd;
        return x;
    endfunction

    function automatic ins_t rnd();
        ins_t x = '0;
        x.vld = ($urandom_range(0, 9) != 0); x.flush = ($urandom_range(0, 7) == 0);
        x.rw = ($urandom_range(0, 4) != 0); x.ld = ($urandom_range(0, 2) == 0);
        x.usem = 3'($urandom);
        for (int k = 0; k < 3; k++) x.rs[k] = 5'($urandom_range(0, 3));
        x.rd = 5'($urandom_range(0, 3));
        return x;
    endfunction

    task automatic drive(input ins_t ia, input ins_t ib);
        a_vld = ia.vld; a_fl = ia.flush; a_rw = ia.rw; a_ld = ia.ld;
        a_use = ia.usem[1:0]; a_rs = {ia.rs[1], ia.rs[0]}; a_rd = ia.rd;
        b_vld = ib.vld; b_fl = ib.flush; b_rw = ib.rw; b_ld = ib.ld;
        b_use = ib.usem; b_rs = ib.rs; b_rd = ib.rd;
    endtask

    // One cycle, entered at posedge+1: comb outputs sampled mid-cycle,
    // registered outputs sampled just after the following edge.
    task automatic step(input ins_t ia, input ins_t ib);
        bit sa, sb, ia_iss, ib_iss;
        logic [5:0] fa, fb;
        drive(ia, ib);
        model(qa, 3, 2, 2, ia, sa, fa);
        model(qb, 4, 3, 3, ib, sb, fb);
        ia_iss = ia.vld & ~ia.flush & ~sa;
        ib_iss = ib.vld & ~ib.flush & ~sb;
        es_a = sa; eb_a = ~ia_iss; es_b = sb; eb_b = ~ib_iss;
        #4;
        os_a = a_stall; ob_a = a_bub; os_b = b_stall; ob_b = b_bub;
        @(posedge clk); #1;
        if (ia_iss) qa.push_back('{now, ia.rd, ia.rw, ia.ld});
        if (ib_iss) qb.push_back('{now, ib.rd, ib.rw, ib.ld});
        if (sa) cnta++;
        if (sb) cntb++;
        now++;
        while (qa.size() > 0 && now - qa[0].cyc > 8) qa.delete(0);
        while (qb.size() > 0 && now - qb[0].cyc > 8) qb.delete(0);
        of_a = a_fwd; oe_a = a_exv; oc_a = a_cnt;
        of_b = b_fwd; oe_b = b_exv; oc_b = b_cnt;
        ef_a = ia_iss ? fa[3:0] : '0; ee_a = ia_iss; ec_a = cnta;
        ef_b = ib_iss ? fb : '0;      ee_b = ib_iss; ec_b = cntb;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(mk(6, 1, 0, 5, 5, 5, 3'b111, 0), mk(6, 1, 0, 5, 5, 5, 3'b111, 0));
        #3;
        total++; if ({a_stall, b_stall} !== 2'b00) $display("FAIL reset_stall got %b want 00", {a_stall, b_stall}); else passed++;
        total++; if ({a_fwd, a_exv, a_cnt} !== '0) $display("FAIL reset_regs_a got %h want 0", {a_fwd, a_exv, a_cnt}); else passed++;
        total++; if ({b_fwd, b_exv, b_cnt} !== '0) $display("FAIL reset_regs_b got %h want 0", {b_fwd, b_exv, b_cnt}); else passed++;
        drive(IDLE, IDLE);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic flush_pipe();
        repeat (4) step(IDLE, IDLE);
    endtask

    task automatic test_alu_forward();
        step(mk(3, 1, 0, 1, 2, 0, 3'b011, 0), IDLE);
        step(mk(4, 1, 0, 3, 1, 0, 3'b011, 0), IDLE);
        total++; if ({os_a, ob_a} !== 2'b00) $display("FAIL alu_fwd_stall got %b want 00", {os_a, ob_a}); else passed++;
        total++; if (of_a !== 4'b0001) $display("FAIL alu_fwd_sel got %h want 1", of_a); else passed++;
        total++; if (oe_a !== 1'b1) $display("FAIL alu_fwd_exv got %b want 1", oe_a); else passed++;
    endtask

    task automatic test_load_use();
        step(mk(5, 1, 1, 1, 0, 0, 3'b001, 0), IDLE);
        step(mk(6, 1, 0, 5, 2, 0, 3'b011, 0), IDLE);
        total++; if ({os_a, ob_a, oe_a} !== 3'b110) $display("FAIL load_use_stall got %b want 110", {os_a, ob_a, oe_a}); else passed++;
        total++; if (oc_a !== 32'd1) $display("FAIL load_use_cnt got %0d want 1", oc_a); else passed++;
        step(mk(6, 1, 0, 5, 2, 0, 3'b011, 0), IDLE);
        total++; if ({os_a, ob_a} !== 2'b00) $display("FAIL load_use_release got %b want 00", {os_a, ob_a}); else passed++;
        total++; if ({of_a, oe_a} !== 5'b0010_1) $display("FAIL load_use_fwd got %b want 00101", {of_a, oe_a}); else passed++;
        total++; if (oc_a !== 32'd1) $display("FAIL load_use_cnt_hold got %0d want 1", oc_a); else passed++;
    endtask

    task automatic test_r0();
        step(mk(0, 1, 1, 1, 1, 0, 3'b000, 0), IDLE);
        step(mk(8, 1, 0, 0, 0, 0, 3'b011, 0), IDLE);
        total++; if (os_a !== 1'b0) $display("FAIL r0_stall got %b want 0", os_a); else passed++;
        total++; if ({of_a, oe_a} !== 5'b0000_1) $display("FAIL r0_fwd got %b want 00001", {of_a, oe_a}); else passed++;
    endtask

    task automatic test_youngest();
        step(mk(7, 1, 0, 0, 0, 0, 3'b000, 0), IDLE);
        step(mk(7, 1, 0, 0, 0, 0, 3'b000, 0), IDLE);
        step(mk(9, 1, 0, 7, 7, 0, 3'b011, 0), IDLE);
        total++; if (os_a !== 1'b0) $display("FAIL youngest_stall got %b want 0", os_a); else passed++;
        total++; if (of_a !== 4'b0101) $display("FAIL youngest_fwd got %b want 0101", of_a); else passed++;
    endtask

    task automatic test_flush_vs_stall();
        step(mk(5, 1, 1, 0, 0, 0, 3'b000, 0), IDLE);
        step(mk(6, 1, 0, 5, 2, 0, 3'b011, 1), IDLE);
        total++; if ({os_a, ob_a} !== 2'b01) $display("FAIL flush_comb got %b want 01", {os_a, ob_a}); else passed++;
        total++; if ({oe_a, of_a} !== 5'b0) $display("FAIL flush_ex got %b want 0", {oe_a, of_a}); else passed++;
        total++; if (oc_a !== 32'd1) $display("FAIL flush_cnt got %0d want 1", oc_a); else passed++;
    endtask

    task automatic test_async_reset();
        step(mk(1, 1, 0, 0, 0, 0, 3'b000, 0), IDLE);
        step(mk(2, 1, 0, 0, 0, 0, 3'b000, 0), IDLE);
        step(mk(5, 1, 1, 0, 0, 0, 3'b000, 0), IDLE);
        drive(mk(6, 1, 0, 5, 0, 0, 3'b001, 0), IDLE);
        #2;
        total++; if ({a_stall, a_exv} !== 2'b11) $display("FAIL pre_reset got %b want 11", {a_stall, a_exv}); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if ({a_stall, a_exv, a_fwd} !== '0) $display("FAIL async_reset_out got %b want 0", {a_stall, a_exv, a_fwd}); else passed++;
        total++; if (a_cnt !== 32'd0) $display("FAIL async_reset_cnt got %0d want 0", a_cnt); else passed++;
        drive(IDLE, IDLE);
        @(posedge clk); #1;
        rst_n = 1'b1;
        qa.delete(); qb.delete(); cnta = 0; cntb = 0;
    endtask

    task automatic test_wide_cfg();
        step(IDLE, mk(3, 1, 0, 1, 2, 0, 3'b011, 0));
        step(IDLE, mk(4, 1, 0, 1, 2, 3, 3'b111, 0));
        total++; if (os_b !== 1'b0) $display("FAIL wide_alu_stall got %b want 0", os_b); else passed++;
        total++; if ({of_b, oe_b} !== 7'b010000_1) $display("FAIL wide_alu_fwd got %b want 0100001", {of_b, oe_b}); else passed++;
        step(IDLE, mk(5, 1, 1, 0, 0, 0, 3'b000, 0));
        step(IDLE, mk(6, 1, 0, 5, 2, 0, 3'b011, 0));
        total++; if ({os_b, ob_b} !== 2'b11) $display("FAIL wide_stall1 got %b want 11", {os_b, ob_b}); else passed++;
        step(IDLE, mk(6, 1, 0, 5, 2, 0, 3'b011, 0));
        total++; if (os_b !== 1'b1) $display("FAIL wide_stall2 got %b want 1", os_b); else passed++;
        total++; if (oc_b !== 32'd2) $display("FAIL wide_cnt got %0d want 2", oc_b); else passed++;
        step(IDLE, mk(6, 1, 0, 5, 2, 0, 3'b011, 0));
        total++; if (os_b !== 1'b0) $display("FAIL wide_release got %b want 0", os_b); else passed++;
        total++; if ({of_b, oe_b} !== 7'b000011_1) $display("FAIL wide_load_fwd got %b want 0000111", {of_b, oe_b}); else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(rnd(), rnd());
            total++;
            if ({os_a, ob_a, of_a, oe_a, oc_a} !== {es_a, eb_a, ef_a, ee_a, ec_a})
                $display("FAIL rand_a cyc %0d got %h want %h", n,
                         {os_a, ob_a, of_a, oe_a, oc_a}, {es_a, eb_a, ef_a, ee_a, ec_a});
            else passed++;
            total++;
            if ({os_b, ob_b, of_b, oe_b, oc_b} !== {es_b, eb_b, ef_b, ee_b, ec_b})
                $display("FAIL rand_b cyc %0d got %h want %h", n,
                         {os_b, ob_b, of_b, oe_b, oc_b}, {es_b, eb_b, ef_b, ee_b, ec_b});
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_alu_forward();    flush_pipe();
        test_load_use();       flush_pipe();
        test_r0();             flush_pipe();
        test_youngest();       flush_pipe();
        test_flush_vs_stall(); flush_pipe();
        test_async_reset();
        test_wide_cfg();       flush_pipe();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
